// File: rtl/nwc_pkg.sv
// Shared types and helpers for the bank output serializer.
package nwc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bos_state_e;

    // Next scan pointer; wraps at num_bank-1 so non-power-of-2 bank counts
    // never visit the unused select codes.
    function automatic int sel_wrap(input int ptr, input int num_bank);
        return (ptr == num_bank - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 word mux; select codes with no matching input give zero.
module mux_n_1 #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*W-1:0]   data_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [W-1:0]     data_o
);

    // Compare against each valid index so out-of-range codes fall through to zero.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = data_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/bank_out_serializer.sv
// Streams a burst of bank words out through a registered valid/ready port.
// Scan mode walks banks from base_sel with wrap; direct mode uses sel_in per beat.
//
// state | meaning
// IDLE  | waiting for start; burst parameters captured on start
// RUN   | loading/presenting beats until the last one is accepted
// DONE  | one-cycle done pulse, busy drops on exit
module bank_out_serializer
    import nwc_pkg::*;
#(
    parameter  int D_WIDTH  = 32,
    parameter  int NUM_BANK = 16,
    localparam int SEL_W    = $clog2(NUM_BANK)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            base_sel,
    input  logic [SEL_W:0]              burst_len,
    input  logic [SEL_W-1:0]            sel_in,
    input  logic [NUM_BANK*D_WIDTH-1:0] Q_in,
    output logic [D_WIDTH-1:0]          Q_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam logic [SEL_W:0] FULL_LEN = (SEL_W+1)'(NUM_BANK);

    bos_state_e         state_q, state_d;
    logic               mode_q, mode_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W:0]     cnt_q, cnt_d;
    logic [D_WIDTH-1:0] q_out_q, q_out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SEL_W-1:0]   mux_sel;
    logic [D_WIDTH-1:0] mux_word;
    logic               load;

    assign mux_sel = mode_q ? ptr_q : sel_in;

    mux_n_1 #(
        .N     (NUM_BANK),
        .W     (D_WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .data_i (Q_in),
        .sel_i  (mux_sel),
        .data_o (mux_word)
    );

    // A new beat may enter the output register when it is empty or being drained.
    assign load = (state_q == RUN) && (!valid_q || out_ready) && (cnt_q != '0);

    // Next-state logic for the FSM, counters and output register.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    ptr_d   = base_sel;
                    cnt_d   = (burst_len == '0) ? FULL_LEN : burst_len;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((cnt_q == '0) && valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (load) begin
                    q_out_d = mux_word;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (mode_q) begin
                        ptr_d = SEL_W'(sel_wrap(int'(ptr_q), NUM_BANK));
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_out_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q_out     = q_out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bank_out_serializer.sv
// Directed bench: a 16-bank instance and a 12-bank instance, bank k holds k+100.
module tb_bank_out_serializer;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bank instance
    logic            a_start, a_mode, a_ready, a_valid, a_busy, a_done;
    logic [3:0]      a_base, a_sel;
    logic [4:0]      a_len;
    logic [16*DW-1:0] a_qin;
    logic [DW-1:0]   a_qout;

    // 12-bank instance
    logic            b_start, b_mode, b_ready, b_valid, b_busy, b_done;
    logic [3:0]      b_base, b_sel;
    logic [4:0]      b_len;
    logic [12*DW-1:0] b_qin;
    logic [DW-1:0]   b_qout;

    bank_out_serializer #(.D_WIDTH(DW), .NUM_BANK(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode),
        .base_sel(a_base), .burst_len(a_len), .sel_in(a_sel), .Q_in(a_qin),
        .Q_out(a_qout), .out_valid(a_valid), .out_ready(a_ready),
        .busy(a_busy), .done(a_done)
    );

    bank_out_serializer #(.D_WIDTH(DW), .NUM_BANK(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
        .base_sel(b_base), .burst_len(b_len), .sel_in(b_sel), .Q_in(b_qin),
        .Q_out(b_qout), .out_valid(b_valid), .out_ready(b_ready),
        .busy(b_busy), .done(b_done)
    );

    int vecs = 0;
    int errs = 0;

    int got [0:31];
    int nbeats;
    int done_cnt;
    int stall_vals [0:7];
    int nstall;
    bit tmo;

    // Pulse start for one cycle with the given burst parameters.
    task automatic kick(input bit inst, input bit md, input int base, input int len);
        @(posedge clk); #1;
        if (inst) begin
            b_start = 1'b1; b_mode = md; b_base = 4'(base); b_len = 5'(len);
        end else begin
            a_start = 1'b1; a_mode = md; a_base = 4'(base); a_len = 5'(len);
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Drain a burst: records accepted beats, optional stall and start re-pulse.
    task automatic collect(input bit inst, input bit dir_sel, input int stall_beat,
                           input int stall_n, input int pulse_at);
        int  stall_left;
        int  post;
        bit  v, d, rdy, st;
        int  q;
        nbeats = 0; done_cnt = 0; nstall = 0; tmo = 1'b0;
        stall_left = stall_n;
        post = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            v = inst ? b_valid : a_valid;
            d = inst ? b_done  : a_done;
            q = inst ? int'(b_qout) : int'(a_qout);
            if (d) done_cnt++;
            st  = (cyc == pulse_at);
            rdy = 1'b1;
            if (v) begin
                if (nbeats == stall_beat && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                    if (nstall < 8) stall_vals[nstall] = q;
                    nstall++;
                end else begin
                    if (nbeats < 32) got[nbeats] = q;
                    nbeats++;
                end
            end
            if (inst) begin
                b_ready = rdy; b_start = st;
            end else begin
                a_ready = rdy; a_start = st;
                if (dir_sel) a_sel = 4'(15 - nbeats);
            end
            if (done_cnt > 0) begin
                post++;
                if (post == 3) break;
            end
        end
        a_start = 1'b0; b_start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        tmo = (post != 3);
    endtask

    task automatic test_reset();
        #12;
        vecs++; if (a_qout !== 16'd0) begin errs++; $display("FAIL reset_qout: got %0d want 0", a_qout); end
        vecs++; if (a_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        vecs++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errs++; $display("FAIL reset_busy_done: got %b%b want 00", a_busy, a_done); end
        vecs++; if (b_valid !== 1'b0 || b_busy !== 1'b0) begin errs++; $display("FAIL reset_b: got %b%b want 00", b_valid, b_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin errs++; $display("FAIL idle_after_reset: got %b%b want 00", a_busy, a_valid); end
    endtask

    // Cycle-exact check of latency, back-to-back beats and done timing.
    task automatic test_scan();
        a_ready = 1'b1;
        kick(1'b0, 1'b1, 3, 4);
        @(negedge clk);
        vecs++; if (a_busy !== 1'b1 || a_valid !== 1'b0) begin errs++; $display("FAIL scan_capture busy/valid: got %b%b want 10", a_busy, a_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++; if (a_valid !== 1'b1 || a_qout !== 16'(103 + i) || a_done !== 1'b0) begin
                errs++; $display("FAIL scan_beat%0d: got v=%b q=%0d d=%b want v=1 q=%0d d=0", i, a_valid, a_qout, a_done, 103 + i);
            end
        end
        @(negedge clk);
        vecs++; if (a_done !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b1) begin
            errs++; $display("FAIL scan_done_cycle: got d=%b v=%b b=%b want 1 0 1", a_done, a_valid, a_busy);
        end
        @(negedge clk);
        vecs++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin errs++; $display("FAIL scan_after_done: got d=%b b=%b want 0 0", a_done, a_busy); end
        vecs++; if (a_qout !== 16'd106) begin errs++; $display("FAIL scan_qout_hold: got %0d want 106", a_qout); end
    endtask

    task automatic test_wrap16();
        int exp_b [4] = '{114, 115, 100, 101};
        kick(1'b0, 1'b1, 14, 4);
        collect(1'b0, 1'b0, -1, 0, -1);
        vecs++; if (tmo || nbeats != 4 || done_cnt != 1) begin errs++; $display("FAIL wrap16_count: got beats=%0d done=%0d tmo=%0d want 4 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (got[i] != exp_b[i]) begin errs++; $display("FAIL wrap16_beat%0d: got %0d want %0d", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_wrap12();
        int exp_b [3] = '{110, 111, 100};
        kick(1'b1, 1'b1, 10, 3);
        collect(1'b1, 1'b0, -1, 0, -1);
        vecs++; if (tmo || nbeats != 3 || done_cnt != 1) begin errs++; $display("FAIL wrap12_count: got beats=%0d done=%0d tmo=%0d want 3 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (got[i] != exp_b[i]) begin errs++; $display("FAIL wrap12_beat%0d: got %0d want %0d", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_len0_12();
        kick(1'b1, 1'b1, 5, 0);
        collect(1'b1, 1'b0, -1, 0, -1);
        vecs++; if (tmo || nbeats != 12 || done_cnt != 1) begin errs++; $display("FAIL len0_12_count: got beats=%0d done=%0d tmo=%0d want 12 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 12; i++) begin
            vecs++; if (got[i] != 100 + (5 + i) % 12) begin errs++; $display("FAIL len0_12_beat%0d: got %0d want %0d", i, got[i], 100 + (5 + i) % 12); end
        end
    endtask

    task automatic test_backpressure();
        kick(1'b0, 1'b1, 0, 5);
        collect(1'b0, 1'b0, 2, 3, -1);
        vecs++; if (tmo || nbeats != 5 || done_cnt != 1) begin errs++; $display("FAIL bp_count: got beats=%0d done=%0d tmo=%0d want 5 1 0", nbeats, done_cnt, tmo); end
        vecs++; if (nstall != 3) begin errs++; $display("FAIL bp_stall_cycles: got %0d want 3", nstall); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (stall_vals[i] != 102) begin errs++; $display("FAIL bp_hold%0d: got %0d want 102", i, stall_vals[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            vecs++; if (got[i] != 100 + i) begin errs++; $display("FAIL bp_beat%0d: got %0d want %0d", i, got[i], 100 + i); end
        end
    endtask

    task automatic test_direct();
        a_sel = 4'd15;
        kick(1'b0, 1'b0, 7, 0);
        collect(1'b0, 1'b1, -1, 0, -1);
        vecs++; if (tmo || nbeats != 16 || done_cnt != 1) begin errs++; $display("FAIL direct_count: got beats=%0d done=%0d tmo=%0d want 16 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 16; i++) begin
            vecs++; if (got[i] != 115 - i) begin errs++; $display("FAIL direct_beat%0d: got %0d want %0d", i, got[i], 115 - i); end
        end
    endtask

    task automatic test_out_of_range();
        b_sel = 4'd13;
        kick(1'b1, 1'b0, 0, 2);
        collect(1'b1, 1'b0, -1, 0, -1);
        vecs++; if (tmo || nbeats != 2 || done_cnt != 1) begin errs++; $display("FAIL oor_count: got beats=%0d done=%0d tmo=%0d want 2 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 2; i++) begin
            vecs++; if (got[i] != 0) begin errs++; $display("FAIL oor_beat%0d: got %0d want 0", i, got[i]); end
        end
    endtask

    task automatic test_start_ignored();
        kick(1'b0, 1'b1, 0, 5);
        a_base = 4'd8;
        a_len  = 5'd2;
        collect(1'b0, 1'b0, -1, 0, 2);
        vecs++; if (tmo || nbeats != 5 || done_cnt != 1) begin errs++; $display("FAIL restart_count: got beats=%0d done=%0d tmo=%0d want 5 1 0", nbeats, done_cnt, tmo); end
        for (int i = 0; i < 5; i++) begin
            vecs++; if (got[i] != 100 + i) begin errs++; $display("FAIL restart_beat%0d: got %0d want %0d", i, got[i], 100 + i); end
        end
        @(negedge clk);
        vecs++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin errs++; $display("FAIL restart_idle: got b=%b v=%b want 0 0", a_busy, a_valid); end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        a_ready = 1'b1;
        kick(1'b0, 1'b1, 0, 8);
        repeat (3) @(negedge clk);
        vecs++; if (a_valid !== 1'b1 || a_busy !== 1'b1) begin errs++; $display("FAIL rstmid_pre: got v=%b b=%b want 1 1", a_valid, a_busy); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (a_qout !== 16'd0 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
            errs++; $display("FAIL rstmid_clear: got q=%0d v=%b b=%b want 0 0 0", a_qout, a_valid, a_busy);
        end
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_done) dcnt++;
        end
        vecs++; if (dcnt != 0) begin errs++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dcnt); end
        vecs++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin errs++; $display("FAIL rstmid_idle: got b=%b v=%b want 0 0", a_busy, a_valid); end
        kick(1'b0, 1'b1, 2, 2);
        collect(1'b0, 1'b0, -1, 0, -1);
        vecs++; if (tmo || nbeats != 2 || got[0] != 102 || got[1] != 103) begin
            errs++; $display("FAIL rstmid_recover: got n=%0d %0d,%0d tmo=%0d want 2 102,103 0", nbeats, got[0], got[1], tmo);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) a_qin[k*DW +: DW] = 16'(k + 100);
        for (int k = 0; k < 12; k++) b_qin[k*DW +: DW] = 16'(k + 100);
        rst_n = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; a_base = '0; a_len = '0; a_sel = '0; a_ready = 1'b1;
        b_start = 1'b0; b_mode = 1'b0; b_base = '0; b_len = '0; b_sel = '0; b_ready = 1'b1;
        test_reset();
        test_scan();
        test_wrap16();
        test_wrap12();
        test_len0_12();
        test_backpressure();
        test_direct();
        test_out_of_range();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
